// File: rtl/silly_1.sv
// silly_1 : byte-wide, input-driven accumulator.
//
// Each clock, ui_in is decoded as {opcode[1:0], operand D[5:0]} and applied
// to an 8-bit accumulator, but only when the byte differs from the one
// sampled on the previous edge. A command held steady therefore executes once.
//
//   opcode 00 ADD  : acc + D (mod 256)
//   opcode 01 XOR  : acc ^ D
//   opcode 10 ROL  : acc rotated left by D[2:0]
//   opcode 11 LOAD : acc = D
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous reset, active HIGH despite the name
//   ui_in  in   [7:0] command byte
//   uo_out out  [7:0] accumulator view, from registers only
//
// Build option:
//   SILLY1_GRAY_OUT_EN  when defined, uo_out presents the accumulator
//                       Gray-coded (acc ^ (acc >> 1)); otherwise binary.

module silly_1 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_XOR  = 2'b01,
        OP_ROL  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    logic [7:0]  acc;
    logic [7:0]  prev;
    logic [7:0]  acc_next;
    logic [7:0]  operand;
    logic [15:0] rol_wide;
    logic        changed;
    op_e         op;

    assign op      = op_e'(ui_in[7:6]);
    assign operand = {2'b00, ui_in[5:0]};
    assign changed = (ui_in != prev);

    // Rotate via a doubled word: bits shifted out of the top half of
    // {acc,acc} are refilled from the lower copy.
    assign rol_wide = {acc, acc} << ui_in[2:0];

    always_comb begin
        acc_next = acc;
        if (changed) begin
            unique case (op)
                OP_ADD:  acc_next = acc + operand;
                OP_XOR:  acc_next = acc ^ operand;
                OP_ROL:  acc_next = rol_wide[15:8];
                OP_LOAD: acc_next = operand;
                default: acc_next = acc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc  <= '0;
            prev <= '0;
        end else begin
            acc  <= acc_next;
            prev <= ui_in;
        end
    end

`ifdef SILLY1_GRAY_OUT_EN
    assign uo_out = acc ^ (acc >> 1);
`else
    assign uo_out = acc;
`endif

endmodule

// File: tb/tb_silly_1.sv
// Directed self-checking bench for silly_1.
// Expected values are hand-computed accumulator contents; when the design is
// built with SILLY1_GRAY_OUT_EN the bench converts them to the Gray view.

module tb_silly_1;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    int unsigned total;
    int unsigned bad;

    silly_1 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] view(input logic [7:0] a);
`ifdef SILLY1_GRAY_OUT_EN
        return a ^ (a >> 1);
`else
        return a;
`endif
    endfunction

    // Drive a byte away from the active edge, then settle just after it.
    task automatic step(input logic [7:0] val);
        @(negedge clk);
        ui_in = val;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        ui_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_init: got %02h expected %02h", uo_out, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_add_hold;
        logic [7:0] exp_seq [4];
        logic [7:0] in_seq  [4];
        in_seq  = '{8'h05, 8'h05, 8'h05, 8'h03};
        exp_seq = '{8'h05, 8'h05, 8'h05, 8'h08};
        for (int i = 0; i < 4; i++) begin
            step(in_seq[i]);
            total++;
            if (uo_out !== view(exp_seq[i])) begin
                bad++;
                $display("FAIL add_hold[%0d]: got %02h expected %02h", i, uo_out, view(exp_seq[i]));
            end
        end
    endtask

    task automatic test_load_xor;
        step(8'hC7);
        total++;
        if (uo_out !== view(8'h07)) begin
            bad++;
            $display("FAIL load: got %02h expected %02h", uo_out, view(8'h07));
        end
        step(8'h4F);
        total++;
        if (uo_out !== view(8'h08)) begin
            bad++;
            $display("FAIL xor: got %02h expected %02h", uo_out, view(8'h08));
        end
    endtask

    task automatic test_rol;
        logic [7:0] in_seq  [3];
        logic [7:0] exp_seq [3];
        in_seq  = '{8'hC1, 8'h83, 8'h85};
        exp_seq = '{8'h01, 8'h08, 8'h01};
        for (int i = 0; i < 3; i++) begin
            step(in_seq[i]);
            total++;
            if (uo_out !== view(exp_seq[i])) begin
                bad++;
                $display("FAIL rol[%0d]: got %02h expected %02h", i, uo_out, view(exp_seq[i]));
            end
        end
    endtask

    task automatic test_add_wrap;
        logic [7:0] in_seq  [5];
        logic [7:0] exp_seq [5];
        in_seq  = '{8'hFF, 8'h3E, 8'h3F, 8'h3E, 8'h3F};
        exp_seq = '{8'h3F, 8'h7D, 8'hBC, 8'hFA, 8'h39};
        for (int i = 0; i < 5; i++) begin
            step(in_seq[i]);
            total++;
            if (uo_out !== view(exp_seq[i])) begin
                bad++;
                $display("FAIL add_wrap[%0d]: got %02h expected %02h", i, uo_out, view(exp_seq[i]));
            end
        end
    endtask

    task automatic test_async_reset;
        // Accumulator holds 0x39 here; assert reset between edges.
        #3;
        rst_n = 1'b1;
        #1;
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: got %02h expected %02h", uo_out, 8'h00);
        end
        for (int v = 1; v < 256; v++) begin
            step(8'(v));
            total++;
            if (uo_out !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold[%02h]: got %02h expected %02h", v, uo_out, 8'h00);
            end
        end
        @(negedge clk);
        ui_in = 8'h00;
        rst_n = 1'b0;
    endtask

    task automatic test_first_zero_noop;
        step(8'h00);
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL first_zero: got %02h expected %02h", uo_out, 8'h00);
        end
        step(8'h41);
        total++;
        if (uo_out !== view(8'h01)) begin
            bad++;
            $display("FAIL post_reset_xor: got %02h expected %02h", uo_out, view(8'h01));
        end
    endtask

    task automatic test_gray_view;
        step(8'hC1);
        step(8'h83);
        total++;
        if (uo_out !== view(8'h08)) begin
            bad++;
            $display("FAIL view_08: got %02h expected %02h", uo_out, view(8'h08));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        ui_in = 8'h00;
        test_reset();
        test_add_hold();
        test_load_xor();
        test_rol();
        test_add_wrap();
        test_async_reset();
        test_first_zero_noop();
        test_gray_view();
        test_add_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/silly_1.md
Name: silly_1

Overview:
- Small byte-wide input-driven accumulator (ALU) for the tiny-tapeout user slot.
- Samples ui_in every clock and decodes it as a 2-bit opcode plus a 6-bit operand.
- Applies the operation to an internal 8-bit accumulator, but only when the input byte has changed since the previous sample.
- Presents the accumulator on uo_out.

Parameters:
- none; all widths are fixed at 8 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-high reset. Port name kept per codebase convention; logic 1 = reset asserted.
- ui_in  input  8  command byte: ui_in[7:6] = opcode, ui_in[5:0] = operand D.
- uo_out  output  8  accumulator view, driven directly from registers with no combinational path from ui_in.

Behaviour:
- State registers:
  - acc[7:0]: accumulator.
  - prev[7:0]: last sampled ui_in.
- Reset:
  - rst_n=1 forces acc=0x00, prev=0x00 and uo_out=0x00 immediately, with no clock edge needed.
  - All state is held while rst_n stays 1; ui_in activity during reset is ignored.
  - Release is on rst_n falling to 0. The first rising edge after release is a normal operating edge.
- Each rising edge with rst_n=0:
  - prev <= ui_in.
  - If ui_in == prev, acc holds. A held input executes exactly once.
  - If ui_in != prev, acc updates by opcode:
    - 00 ADD: acc <= acc + {2'b00,D}, modulo 256; carry discarded.
    - 01 XOR: acc <= acc ^ {2'b00,D}.
    - 10 ROL: acc <= acc rotated left by D[2:0] positions; D[5:3] ignored; rotate by 0 = hold.
    - 11 LOAD: acc <= {2'b00,D}.
- Consequence of reset: because prev resets to 0x00, a first input of 0x00 after reset is a no-op.
- Latency: the command sampled at edge N is visible on uo_out after edge N. uo_out changes only on clock edges or on reset assertion.
- Unknown (X) ui_in is not required to be handled; the bench drives known values before releasing reset.

Optional Feature:
- Macro: SILLY1_GRAY_OUT_EN.
- Defined: uo_out = acc ^ (acc >> 1), i.e. the Gray-coded accumulator. This is a combinational function of the acc register only. Reset still yields 0x00.
- Undefined: uo_out = acc, binary.
- Internal acc behaviour is identical in both builds.

Test Plan (binary build):
- Async reset: with acc=0x39, raise rst_n to 1 mid-cycle. uo_out must read 0x00 before the next clock edge and stay 0x00 while ui_in sweeps 0x01..0xFF.
- ADD and hold: after reset release, drive ui_in=0x05 for 3 edges, then 0x03 → uo_out 0x05 after the first edge, still 0x05 after edges 2–3, then 0x08.
- LOAD/XOR: drive 0xC7 then 0x4F → uo_out 0x07, then 0x08.
- ROL: drive 0xC1, then 0x83, then 0x85 → uo_out 0x01, then 0x08, then 0x01 (rotation wraps bit 7 into bit 0).
- ADD wrap: drive 0xFF (load 0x3F), then 0x3E, 0x3F, 0x3E, 0x3F → uo_out 0x3F, 0x7D, 0xBC, 0xFA, 0x39.
- Gray build: load acc=0x08 via 0xC1 then 0x83 → uo_out 0x0C. Repeat the ADD-wrap sequence and check every output equals acc^(acc>>1).
